// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receives 8N1 bytes from an asynchronous serial line and buffers them in a
// first-word-fall-through FIFO for system logic. Bit timing comes from an
// internal clock divider (CPB = CLK_HZ/BAUD clocks per bit), so everything
// runs in the single clk_i domain.
//
// Ports:
//   clk_i       system clock, rising edge
//   rstn_i      synchronous reset, active low
//   serial_i    asynchronous RX line, idle high
//   byte_o      head-of-FIFO byte, valid while empty_o=0 (0 when empty)
//   rden_i      pop the head byte; ignored while empty
//   empty_o     FIFO holds no bytes
//   full_o      FIFO holds 2**DEPTH_LOG2 bytes
//   count_o     number of bytes held
//   frame_err_o one-cycle pulse when a stop bit is low (byte discarded)
//   overrun_o   sticky: a good byte was dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  serial_i,
  output logic [7:0]            byte_o,
  input  logic                  rden_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int TW    = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [TW-1:0]         HALF_RELOAD = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0]         FULL_RELOAD = TW'(CPB - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic                    rxMeta_q;
  logic                    rxSync_q;
  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [2:0]              bitIdx_q, bitIdx_d;
  logic [7:0]              shift_q, shift_d;
  logic                    frameErr_q, frameErr_d;
  logic                    push;
  logic                    pop;
  logic                    accept;
  logic                    timerDone;

  logic [7:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wrPtr_q;
  logic [DEPTH_LOG2-1:0]   rdPtr_q;
  logic [DEPTH_LOG2:0]     count_q;
  logic                    overrun_q;

  // Two-flop synchronizer; both stages come out of reset at the idle level
  // so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= serial_i;
      rxSync_q <= rxMeta_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign timerDone = (timer_q == '0);

  // Receiver next-state logic. The start bit is sampled half a bit period
  // after the falling edge, so every later sample lands mid-bit.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    frameErr_d = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxSync_q) begin
          timer_d = HALF_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!timerDone) begin
          timer_d = timer_q - TW'(1);
        end else if (rxSync_q) begin
          state_d = S_IDLE;
        end else begin
          timer_d  = FULL_RELOAD;
          bitIdx_d = 3'd0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (!timerDone) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d  = {rxSync_q, shift_q[7:1]};
          timer_d  = FULL_RELOAD;
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (!timerDone) begin
          timer_d = timer_q - TW'(1);
        end else if (rxSync_q) begin
          // Returning straight to idle lets a start bit that follows
          // immediately be caught on the next cycle.
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frameErr_d = 1'b1;
          state_d    = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not retrigger a new frame.
        if (rxSync_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A full FIFO can still take a byte when the head is popped in the same
  // cycle, since the slot being written is the one being freed.
  assign pop    = rden_i && (count_q != '0);
  assign accept = push && ((count_q != DEPTH_CNT) || pop);

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        wrPtr_q <= wrPtr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + DEPTH_LOG2'(1);
      end
      if (accept && !pop) begin
        count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
      end else if (pop && !accept) begin
        count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
      end
      if (push && !accept) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because byte_o is masked when empty.
  always_ff @(posedge clk_i) begin
    if (rstn_i && accept) begin
      mem_q[wrPtr_q] <= shift_q;
    end
  end

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == DEPTH_CNT);
  assign count_o     = count_q;
  assign byte_o      = empty_o ? 8'h00 : mem_q[rdPtr_q];
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo with CPB=10 and a 4-entry FIFO. Serial
// frames are driven bit by bit (10 clocks per bit); each scenario task
// compares outputs against hand-computed values.
module tb_uart_rx_fifo;

  logic       clk_i;
  logic       rstn_i;
  logic       serial_i;
  logic [7:0] byte_o;
  logic       rden_i;
  logic       empty_o;
  logic       full_o;
  logic [2:0] count_o;
  logic       frame_err_o;
  logic       overrun_o;

  int checks;
  int failures;
  int frameErrPulses;

  uart_rx_fifo #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .serial_i    (serial_i),
    .byte_o      (byte_o),
    .rden_i      (rden_i),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  // 10 ns clock period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counts every cycle where the frame error pulse is high.
  always @(negedge clk_i) begin
    if (rstn_i && frame_err_o) frameErrPulses++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, 10 clocks each,
  // stopping early after maxCycles clocks.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int maxCycles);
    logic [9:0] frame;
    int cyc;
    frame = {stopBit, data, 1'b0};
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      serial_i = frame[i];
      for (int k = 0; k < 10; k++) begin
        if (cyc >= maxCycles) return;
        @(posedge clk_i);
        #1;
        cyc++;
      end
    end
  endtask

  task automatic doReset();
    serial_i = 1'b1;
    rden_i   = 1'b0;
    rstn_i   = 1'b0;
    tick(3);
    rstn_i   = 1'b1;
    tick(2);
  endtask

  task automatic popHead();
    rden_i = 1'b1;
    tick(1);
    rden_i = 1'b0;
  endtask

  task automatic test_reset();
    serial_i = 1'b1;
    rden_i   = 1'b0;
    rstn_i   = 1'b0;
    tick(3);
    checks++;
    if ({empty_o, full_o, count_o, byte_o, frame_err_o, overrun_o} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: empty=%b full=%b count=%0d byte=%h fe=%b ov=%b, required 1 0 0 00 0 0",
               empty_o, full_o, count_o, byte_o, frame_err_o, overrun_o);
    end
    rstn_i = 1'b1;
    tick(2);
  endtask

  task automatic test_single_byte();
    int lat;
    lat = -1;
    fork
      sendFrame(8'hA5, 1'b1, 100);
      begin
        for (int c = 1; c <= 150; c++) begin
          @(posedge clk_i);
          #1;
          if (!empty_o) begin
            lat = c;
            break;
          end
        end
      end
    join
    // 2 sync + 1 detect + 5 half-bit + 9 bits x 10 = empty drops after edge 98.
    checks++;
    if (lat !== 98) begin
      failures++;
      $display("[TB] FAIL single_latency: got %0d cycles, required 98", lat);
    end
    checks++;
    if (byte_o !== 8'hA5 || count_o !== 3'd1) begin
      failures++;
      $display("[TB] FAIL single_data: byte=%h count=%0d, required a5 1", byte_o, count_o);
    end
    popHead();
    checks++;
    if (empty_o !== 1'b1 || count_o !== 3'd0) begin
      failures++;
      $display("[TB] FAIL single_pop: empty=%b count=%0d, required 1 0", empty_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int errBefore;
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h3C;
    errBefore = frameErrPulses;
    for (int i = 0; i < 3; i++) sendFrame(exp[i], 1'b1, 100);
    tick(2);
    checks++;
    if (count_o !== 3'd3) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d, required 3", count_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (byte_o !== exp[i]) begin
        failures++;
        $display("[TB] FAIL b2b_read%0d: got %h, required %h", i, byte_o, exp[i]);
      end
      popHead();
    end
    checks++;
    if (frameErrPulses !== errBefore) begin
      failures++;
      $display("[TB] FAIL b2b_frame_err: got %0d pulses, required 0", frameErrPulses - errBefore);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) sendFrame(8'(i), 1'b1, 100);
    tick(2);
    checks++;
    if (full_o !== 1'b1 || overrun_o !== 1'b0 || count_o !== 3'd4) begin
      failures++;
      $display("[TB] FAIL ovf_full: full=%b ov=%b count=%0d, required 1 0 4", full_o, overrun_o, count_o);
    end
    sendFrame(8'h05, 1'b1, 100);
    tick(2);
    checks++;
    if (overrun_o !== 1'b1 || count_o !== 3'd4) begin
      failures++;
      $display("[TB] FAIL ovf_overrun: ov=%b count=%0d, required 1 4", overrun_o, count_o);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (byte_o !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL ovf_read%0d: got %h, required %h", i, byte_o, 8'(i));
      end
      popHead();
    end
    checks++;
    if (empty_o !== 1'b1 || overrun_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_drained: empty=%b ov=%b, required 1 1", empty_o, overrun_o);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    doReset();
    sendFrame(8'h11, 1'b1, 100);
    sendFrame(8'h22, 1'b1, 100);
    sendFrame(8'h33, 1'b1, 100);
    sendFrame(8'h44, 1'b1, 100);
    tick(2);
    // Stop bit is sampled at edge 98 of the frame; rden_i covers that edge.
    fork
      sendFrame(8'h77, 1'b1, 100);
      begin
        repeat (97) @(posedge clk_i);
        #1;
        rden_i = 1'b1;
        @(posedge clk_i);
        #1;
        rden_i = 1'b0;
      end
    join
    checks++;
    if (count_o !== 3'd4 || overrun_o !== 1'b0 || byte_o !== 8'h22) begin
      failures++;
      $display("[TB] FAIL fullpp_state: count=%0d ov=%b byte=%h, required 4 0 22", count_o, overrun_o, byte_o);
    end
    exp[0] = 8'h22;
    exp[1] = 8'h33;
    exp[2] = 8'h44;
    exp[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (byte_o !== exp[i]) begin
        failures++;
        $display("[TB] FAIL fullpp_read%0d: got %h, required %h", i, byte_o, exp[i]);
      end
      popHead();
    end
  endtask

  task automatic test_frame_error();
    int errBefore;
    errBefore = frameErrPulses;
    sendFrame(8'h55, 1'b0, 100);
    tick(40);
    serial_i = 1'b1;
    tick(20);
    checks++;
    if (frameErrPulses !== errBefore + 1) begin
      failures++;
      $display("[TB] FAIL ferr_pulses: got %0d, required 1", frameErrPulses - errBefore);
    end
    checks++;
    if (empty_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ferr_no_push: empty=%b, required 1", empty_o);
    end
    sendFrame(8'h12, 1'b1, 100);
    tick(2);
    checks++;
    if (byte_o !== 8'h12 || count_o !== 3'd1 || frameErrPulses !== errBefore + 1) begin
      failures++;
      $display("[TB] FAIL ferr_recover: byte=%h count=%0d pulses=%0d, required 12 1 1",
               byte_o, count_o, frameErrPulses - errBefore);
    end
    popHead();
  endtask

  task automatic test_glitch_and_reset();
    int errBefore;
    errBefore = frameErrPulses;
    serial_i = 1'b0;
    tick(3);
    serial_i = 1'b1;
    tick(30);
    checks++;
    if (empty_o !== 1'b1 || frameErrPulses !== errBefore) begin
      failures++;
      $display("[TB] FAIL glitch: empty=%b pulses=%0d, required 1 0", empty_o, frameErrPulses - errBefore);
    end
    sendFrame(8'h99, 1'b1, 50);
    serial_i = 1'b1;
    rstn_i   = 1'b0;
    tick(1);
    checks++;
    if ({empty_o, full_o, count_o, byte_o, frame_err_o, overrun_o} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: empty=%b full=%b count=%0d byte=%h fe=%b ov=%b, required 1 0 0 00 0 0",
               empty_o, full_o, count_o, byte_o, frame_err_o, overrun_o);
    end
    tick(1);
    rstn_i = 1'b1;
    tick(150);
    checks++;
    if (empty_o !== 1'b1 || count_o !== 3'd0 || frameErrPulses !== errBefore) begin
      failures++;
      $display("[TB] FAIL midreset_no_write: empty=%b count=%0d pulses=%0d, required 1 0 0",
               empty_o, count_o, frameErrPulses - errBefore);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    frameErrPulses = 0;
    rstn_i         = 1'b0;
    serial_i       = 1'b1;
    rden_i         = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_frame_error();
    test_glitch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
